// File: rtl/efuse_read_seq.sv
// eFuse read sequencer: setup/strobe/hold timing toward the eFuse mux, plus the post-reset autoload into the shadow file.
// Optional feature macro: EFUSE_AUTOLOAD_EN (autoload after every reset; when undefined autoload_done_o is tied high).
module efuse_read_seq #(
  parameter int NR      = 64,
  parameter int T_SETUP = 2,
  parameter int T_AEN   = 4,
  parameter int T_HOLD  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  input  logic [7:0] req_addr_i,
  output logic       req_done_o,
  output logic [7:0] req_rdata_o,
  output logic       req_err_o,
  output logic       busy_read_o,
  output logic       read_pgmen_o,
  output logic       read_rden_o,
  output logic       read_aen_o,
  output logic [7:0] read_addr_o,
  input  logic [7:0] read_rdata_i,
  output logic       shadow_we_o,
  output logic [7:0] shadow_addr_o,
  output logic [7:0] shadow_wdata_o,
  output logic       autoload_done_o
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_CAPTURE} state_e;

  state_e     state_q;
  logic [7:0] timer_q, addr_q, rdata_q;
  logic       busy_q, rden_q, aen_q, done_q, err_q;
  logic       req_oor;

  // 9-bit compare so that NR = 256 never flags an 8-bit address
  assign req_oor = {1'b0, req_addr_i} >= 9'(NR);

`ifdef EFUSE_AUTOLOAD_EN
  logic       we_q, al_done_q;
  logic [7:0] sh_addr_q, sh_data_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      rden_q  <= 1'b0;
      aen_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef EFUSE_AUTOLOAD_EN
      we_q      <= 1'b0;
      al_done_q <= 1'b0;
      sh_addr_q <= '0;
      sh_data_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef EFUSE_AUTOLOAD_EN
      we_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
`ifdef EFUSE_AUTOLOAD_EN
          if (!al_done_q) begin
            addr_q  <= '0;
            state_q <= S_SETUP;
            timer_q <= 8'(T_SETUP - 1);
            busy_q  <= 1'b1;
            rden_q  <= 1'b1;
          end else
`endif
          if (req_valid_i) begin
            if (req_oor) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              addr_q  <= req_addr_i;
              state_q <= S_SETUP;
              timer_q <= 8'(T_SETUP - 1);
              busy_q  <= 1'b1;
              rden_q  <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (timer_q == 8'd0) begin
            state_q <= S_STROBE;
            timer_q <= 8'(T_AEN - 1);
            aen_q   <= 1'b1;
          end else begin
            timer_q <= timer_q - 8'd1;
          end
        end
        S_STROBE: begin
          if (timer_q == 8'd0) begin
            state_q <= S_HOLD;
            timer_q <= 8'(T_HOLD - 1);
            aen_q   <= 1'b0;
          end else begin
            timer_q <= timer_q - 8'd1;
          end
        end
        S_HOLD: begin
          if (timer_q == 8'd0) state_q <= S_CAPTURE;
          else                 timer_q <= timer_q - 8'd1;
        end
        S_CAPTURE: begin
`ifdef EFUSE_AUTOLOAD_EN
          // autoload is the only traffic until it completes
          if (!al_done_q) begin
            we_q      <= 1'b1;
            sh_addr_q <= addr_q;
            sh_data_q <= read_rdata_i;
            if (addr_q == 8'(NR - 1)) begin
              al_done_q <= 1'b1;
              state_q   <= S_IDLE;
              busy_q    <= 1'b0;
              rden_q    <= 1'b0;
            end else begin
              addr_q  <= addr_q + 8'd1;
              state_q <= S_SETUP;
              timer_q <= 8'(T_SETUP - 1);
            end
          end else
`endif
          begin
            done_q  <= 1'b1;
            rdata_q <= read_rdata_i;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            rden_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          rden_q  <= 1'b0;
          aen_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_done_o   = done_q;
  assign req_rdata_o  = rdata_q;
  assign req_err_o    = err_q;
  assign busy_read_o  = busy_q;
  assign read_pgmen_o = 1'b0;
  assign read_rden_o  = rden_q;
  assign read_aen_o   = aen_q;
  assign read_addr_o  = addr_q;

`ifdef EFUSE_AUTOLOAD_EN
  assign shadow_we_o     = we_q;
  assign shadow_addr_o   = sh_addr_q;
  assign shadow_wdata_o  = sh_data_q;
  assign autoload_done_o = al_done_q;
`else
  assign shadow_we_o     = 1'b0;
  assign shadow_addr_o   = '0;
  assign shadow_wdata_o  = '0;
  assign autoload_done_o = 1'b1;
`endif

endmodule

// File: tb/tb_efuse_read_seq.sv
// Scoreboard bench for efuse_read_seq; covers both EFUSE_AUTOLOAD_EN builds.
module tb_efuse_read_seq;
  localparam int NR = 64, TS = 2, TA = 4, TH = 2;
  localparam int LAT  = TS + TA + TH + 2;
  localparam int BYTE = TS + TA + TH + 1;

  logic       clk = 1'b0, rst = 1'b1, req_valid = 1'b0;
  logic [7:0] req_addr = '0;
  logic       req_done, req_err, busy_read, read_pgmen, read_rden, read_aen, shadow_we, autoload_done;
  logic [7:0] req_rdata, read_addr, read_rdata, shadow_addr, shadow_wdata;

  int tests = 0, fails = 0, cyc = 0;
  typedef struct { logic [7:0] data; logic err; int due; } exp_t;
  exp_t expq[$];
  logic [7:0] last_rdata = '0;
  int   al_base = 0, al_idx = 0;
  logic al_seen = 1'b0, pg_seen = 1'b0, aen_abort = 1'b0;
  int   aen_run = 0;

  efuse_read_seq #(.NR(NR), .T_SETUP(TS), .T_AEN(TA), .T_HOLD(TH)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_done_o(req_done), .req_rdata_o(req_rdata), .req_err_o(req_err),
    .busy_read_o(busy_read), .read_pgmen_o(read_pgmen), .read_rden_o(read_rden),
    .read_aen_o(read_aen), .read_addr_o(read_addr), .read_rdata_i(read_rdata),
    .shadow_we_o(shadow_we), .shadow_addr_o(shadow_addr), .shadow_wdata_o(shadow_wdata),
    .autoload_done_o(autoload_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // fuse model: byte i holds i ^ 8'hA5
  assign read_rdata = read_rden ? (read_addr ^ 8'hA5) : 8'h00;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      pg_seen = pg_seen | read_pgmen;
      if (req_done) begin
        chk("done_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          exp_t e;
          e = expq.pop_front();
          chk("rdata", req_rdata, e.data);
          chk("err", req_err, e.err);
          chk("done_cycle", cyc, e.due);
        end
      end
      if (read_aen) begin
        aen_run++;
      end else if (aen_run > 0) begin
        if (!aen_abort) chk("aen_width", aen_run, TA);
        aen_run = 0;
        aen_abort = 1'b0;
      end
`ifdef EFUSE_AUTOLOAD_EN
      if (shadow_we) begin
        chk("sh_addr", shadow_addr, al_idx);
        chk("sh_data", shadow_wdata, al_idx[7:0] ^ 8'hA5);
        chk("sh_cycle", cyc, al_base + 1 + (al_idx + 1) * BYTE);
        al_idx++;
      end
      if (autoload_done && !al_seen) begin
        al_seen = 1'b1;
        chk("al_done_cycle", cyc, al_base + 577);
        chk("al_count", al_idx, NR);
      end
`endif
    end else if (aen_run > 0) begin
      aen_abort = 1'b1;
    end
  end

  task automatic issue(logic [7:0] a, logic e, int acc);
    exp_t x;
    req_valid = 1'b1;
    req_addr  = a;
    x.err  = e;
    x.data = e ? last_rdata : (a ^ 8'hA5);
    x.due  = acc + (e ? 1 : LAT);
    if (!e) last_rdata = x.data;
    expq.push_back(x);
  endtask

  task automatic wait_done(int lim);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!req_done && n < lim);
    if (!req_done) chk("done_timeout", req_done, 1);
  endtask

  task automatic wait_al();
    int n = 0;
    while (!autoload_done && n < 700) begin @(posedge clk); #1; n++; end
    chk("al_done_seen", autoload_done, 1);
  endtask

  task automatic rst_on_aen();
    int n = 0;
    while (!read_aen && n < 100) begin @(posedge clk); #1; n++; end
    chk("aen_seen", read_aen, 1);
    rst = 1'b1; req_valid = 1'b0; expq.delete();
    @(posedge clk); #1;
    rst = 1'b0; al_base = cyc; al_idx = 0; al_seen = 1'b0; last_rdata = '0;
    chk("rst_aen", read_aen, 0);
    chk("rst_rden", read_rden, 0);
    chk("rst_busy", busy_read, 0);
    chk("rst_done", req_done, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy0", busy_read, 0);
    chk("rst_rden0", read_rden, 0);
    chk("rst_aen0", read_aen, 0);
    chk("rst_done0", req_done, 0);
    chk("rst_rdata0", req_rdata, 0);
    chk("rst_we0", shadow_we, 0);
`ifdef EFUSE_AUTOLOAD_EN
    chk("rst_al_done", autoload_done, 0);
    rst = 1'b0; al_base = cyc;
    // request raised at cycle 5 of autoload waits for autoload_done
    repeat (5) @(posedge clk);
    #1;
    issue(8'h10, 1'b0, al_base + 577);
    wait_done(700);
    req_valid = 1'b0;
`else
    chk("rst_al_done", autoload_done, 1);
    rst = 1'b0;
`endif
    issue(8'h00, 1'b0, cyc);
    wait_done(50);
    req_valid = 1'b0;
    @(posedge clk); #1;
    issue(8'h10, 1'b0, cyc);
    wait_done(50);
    issue(8'h3F, 1'b0, cyc);   // back-to-back in the done cycle
    wait_done(50);
    req_valid = 1'b0;
    @(posedge clk); #1;
    issue(8'd64, 1'b1, cyc);
    wait_done(5);
    chk("oor_busy", busy_read, 0);
    chk("oor_rden", read_rden, 0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    issue(8'hFF, 1'b1, cyc);
    wait_done(5);
    chk("oor2_busy", busy_read, 0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    issue(8'h20, 1'b0, cyc);
    rst_on_aen();
`ifdef EFUSE_AUTOLOAD_EN
    repeat (20) @(posedge clk);
    #1;
    rst_on_aen();
    wait_al();
`endif
    repeat (3) @(posedge clk);
    #1;
    issue(8'h05, 1'b0, cyc);
    wait_done(50);
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pgmen_never", pg_seen, 0);
    chk("queue_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
